// File: rtl/cpu_decode_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_decode_stage_if
//  Description : Upstream/downstream handshake and decoded-field bundle
//                for the moxie decode stage.
//  Revision    : 1.0  initial release
// ============================================================================
interface cpu_decode_stage_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 8
);
    logic [15:0]       opcode_i;
    logic [DATA_W-1:0] operand_i;
    logic [ADDR_W-1:0] pc_i;
    logic              valid_i;
    logic              ready_o;
    logic              flush_i;
    logic              valid_o;
    logic              ready_i;
    logic [3:0]        class_o;
    logic [3:0]        alu_op_o;
    logic [3:0]        rega_o;
    logic [3:0]        regb_o;
    logic [DATA_W-1:0] imm_o;
    logic [3:0]        cond_o;
    logic [1:0]        mem_size_o;
    logic              illegal_o;
    logic [ADDR_W-1:0] pc_o;
    logic [CNT_W-1:0]  ill_count_o;

    modport slave (
        input  opcode_i, operand_i, pc_i, valid_i, flush_i, ready_i,
        output ready_o, valid_o, class_o, alu_op_o, rega_o, regb_o, imm_o,
               cond_o, mem_size_o, illegal_o, pc_o, ill_count_o
    );

    modport master (
        output opcode_i, operand_i, pc_i, valid_i, flush_i, ready_i,
        input  ready_o, valid_o, class_o, alu_op_o, rega_o, regb_o, imm_o,
               cond_o, mem_size_o, illegal_o, pc_o, ill_count_o
    );
endinterface
`default_nettype wire

// File: rtl/cpu_decode_stage.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_decode_stage
//  Description : Moxie decode stage with 2-entry skid buffer and saturating
//                illegal-opcode counter. Define CPU_DECODE_TRACE_EN for a
//                simulation-only disassembly trace of accepted beats.
//  Revision    : 1.0  initial release
// ============================================================================
module cpu_decode_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    cpu_decode_stage_if.slave   bus
);
    localparam logic [3:0] c_CLS_NOP = 4'd0,  c_CLS_ALU = 4'd1,  c_CLS_MOVE = 4'd2;
    localparam logic [3:0] c_CLS_LOAD = 4'd3, c_CLS_STORE = 4'd4, c_CLS_BRANCH = 4'd5;
    localparam logic [3:0] c_CLS_JUMP = 4'd6, c_CLS_CALL = 4'd7, c_CLS_RET = 4'd8;
    localparam logic [3:0] c_CLS_STACK = 4'd9, c_CLS_SWI = 4'd10, c_CLS_BRK = 4'd11;
    localparam logic [3:0] c_CLS_SREG = 4'd12, c_CLS_ILL = 4'd15;

    typedef struct packed {
        logic [3:0]        cls;
        logic [3:0]        alu;
        logic [3:0]        rega;
        logic [3:0]        regb;
        logic [DATA_W-1:0] imm;
        logic [3:0]        cond;
        logic [1:0]        size;
        logic [ADDR_W-1:0] pc;
    } dec_t;

    typedef enum logic [1:0] {S_EMPTY = 2'd0, S_ONE = 2'd1, S_TWO = 2'd2} state_t;

    state_t            r_state, w_next;
    logic              r_ready;
    dec_t              r_out, r_skid, w_dec;
    logic [CNT_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] w_tgt;
    logic              w_in, w_out, w_load_out, w_load_skid, w_skid_to_out;
    logic [15:0]       w_op;

    assign w_op  = bus.opcode_i;
    assign w_in  = bus.valid_i & r_ready;
    assign w_out = (r_state != S_EMPTY) & bus.ready_i;
    assign w_tgt = bus.pc_i + ADDR_W'(2) + {{(ADDR_W-11){w_op[9]}}, w_op[9:0], 1'b0};

    always_comb begin
        w_dec      = '0;
        w_dec.pc   = bus.pc_i;
        w_dec.size = 2'd2;
        case (w_op[15:14])
            2'b10: begin
                w_dec.rega = w_op[11:8];
                w_dec.imm  = DATA_W'(w_op[7:0]);
                case (w_op[13:12])
                    2'b00:   w_dec.cls = c_CLS_ALU;
                    2'b01:   begin w_dec.cls = c_CLS_ALU; w_dec.alu = 4'd1; end
                    default: w_dec.cls = c_CLS_SREG;
                endcase
            end
            2'b11: begin
                w_dec.cond = w_op[13:10];
                w_dec.imm  = DATA_W'(w_tgt);
                w_dec.cls  = (w_op[13:10] > 4'd9) ? c_CLS_ILL : c_CLS_BRANCH;
            end
            default: begin
                w_dec.rega = w_op[7:4];
                w_dec.regb = w_op[3:0];
                w_dec.imm  = bus.operand_i;
                case (w_op[15:8])
                    8'h00:                  w_dec.cls = c_CLS_NOP;
                    8'h01, 8'h02:           w_dec.cls = c_CLS_MOVE;
                    8'h1b:                  begin w_dec.cls = c_CLS_MOVE; w_dec.size = 2'd0; end
                    8'h20:                  begin w_dec.cls = c_CLS_MOVE; w_dec.size = 2'd1; end
                    8'h03, 8'h19:           w_dec.cls = c_CLS_CALL;
                    8'h04:                  w_dec.cls = c_CLS_RET;
                    8'h06, 8'h07:           w_dec.cls = c_CLS_STACK;
                    8'h08, 8'h0a, 8'h0c:    w_dec.cls = c_CLS_LOAD;
                    8'h1c, 8'h1d, 8'h36:    begin w_dec.cls = c_CLS_LOAD; w_dec.size = 2'd0; end
                    8'h21, 8'h22, 8'h38:    begin w_dec.cls = c_CLS_LOAD; w_dec.size = 2'd1; end
                    8'h09, 8'h0b, 8'h0d:    w_dec.cls = c_CLS_STORE;
                    8'h1e, 8'h1f, 8'h37:    begin w_dec.cls = c_CLS_STORE; w_dec.size = 2'd0; end
                    8'h23, 8'h24, 8'h39:    begin w_dec.cls = c_CLS_STORE; w_dec.size = 2'd1; end
                    8'h1a, 8'h25:           w_dec.cls = c_CLS_JUMP;
                    8'h30:                  w_dec.cls = c_CLS_SWI;
                    8'h35:                  w_dec.cls = c_CLS_BRK;
                    8'h05: begin w_dec.cls = c_CLS_ALU; w_dec.alu = 4'd0;  end
                    8'h29: begin w_dec.cls = c_CLS_ALU; w_dec.alu = 4'd1;  end
                    8'h26: begin w_dec.cls = c_CLS_ALU; w_dec.alu = 4'd2;  end
                    8'h2b: begin w_dec.cls = c_CLS_ALU; w_dec.alu = 4'd3;  end
                    8'h2e: begin w_dec.cls = c_CLS_ALU; w_dec.alu = 4'd4;  end
                    8'h27: begin w_dec.cls = c_CLS_ALU; w_dec.alu = 4'd5;  end
                    8'h2d: begin w_dec.cls = c_CLS_ALU; w_dec.alu = 4'd6;  end
                    8'h28: begin w_dec.cls = c_CLS_ALU; w_dec.alu = 4'd7;  end
                    8'h2f: begin w_dec.cls = c_CLS_ALU; w_dec.alu = 4'd8;  end
                    8'h31: begin w_dec.cls = c_CLS_ALU; w_dec.alu = 4'd9;  end
                    8'h32: begin w_dec.cls = c_CLS_ALU; w_dec.alu = 4'd10; end
                    8'h33: begin w_dec.cls = c_CLS_ALU; w_dec.alu = 4'd11; end
                    8'h34: begin w_dec.cls = c_CLS_ALU; w_dec.alu = 4'd12; end
                    8'h2a: begin w_dec.cls = c_CLS_ALU; w_dec.alu = 4'd13; end
                    8'h2c: begin w_dec.cls = c_CLS_ALU; w_dec.alu = 4'd14; end
                    8'h0e: begin w_dec.cls = c_CLS_ALU; w_dec.alu = 4'd15; end
                    default:                w_dec.cls = c_CLS_ILL;
                endcase
            end
        endcase
    end

    // Skid-buffer control; flush cancels every load and empties the buffer.
    always_comb begin
        w_next        = r_state;
        w_load_out    = 1'b0;
        w_load_skid   = 1'b0;
        w_skid_to_out = 1'b0;
        case (r_state)
            S_EMPTY: if (w_in) begin w_next = S_ONE; w_load_out = 1'b1; end
            S_ONE: begin
                if (w_in && !w_out)      begin w_next = S_TWO; w_load_skid = 1'b1; end
                else if (w_in && w_out)  w_load_out = 1'b1;
                else if (w_out)          w_next = S_EMPTY;
            end
            S_TWO: if (w_out) begin w_next = S_ONE; w_skid_to_out = 1'b1; end
            default: w_next = S_EMPTY;
        endcase
        if (bus.flush_i) begin
            w_next        = S_EMPTY;
            w_load_out    = 1'b0;
            w_load_skid   = 1'b0;
            w_skid_to_out = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_EMPTY;
            r_ready <= 1'b1;
        end else begin
            r_state <= w_next;
            r_ready <= (w_next != S_TWO);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_out  <= '0;
            r_skid <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_load_out)         r_out <= w_dec;
            else if (w_skid_to_out) r_out <= r_skid;
            if (w_load_skid)        r_skid <= w_dec;
            if (w_in && !bus.flush_i && (w_dec.cls == c_CLS_ILL) && (r_cnt != {CNT_W{1'b1}}))
                r_cnt <= r_cnt + 1'b1;
        end
    end

    assign bus.ready_o     = r_ready;
    assign bus.valid_o     = (r_state != S_EMPTY);
    assign bus.class_o     = r_out.cls;
    assign bus.alu_op_o    = r_out.alu;
    assign bus.rega_o      = r_out.rega;
    assign bus.regb_o      = r_out.regb;
    assign bus.imm_o       = r_out.imm;
    assign bus.cond_o      = r_out.cond;
    assign bus.mem_size_o  = r_out.size;
    assign bus.illegal_o   = (r_out.cls == c_CLS_ILL);
    assign bus.pc_o        = r_out.pc;
    assign bus.ill_count_o = r_cnt;

`ifdef CPU_DECODE_TRACE_EN
    string c_f1_mnem [58] = '{"nop","ldi.l","mov","jsra","ret","add.l","push","pop","lda.l",
        "sta.l","ld.l","st.l","ldo.l","sto.l","cmp","bad","bad","bad","bad","bad","bad","bad",
        "bad","bad","bad","jsr","jmpa","ldi.b","ld.b","lda.b","st.b","sta.b","ldi.s","ld.s",
        "lda.s","st.s","sta.s","jmp","and","lshr","ashl","sub.l","neg","or","not","ashr","xor",
        "mul.l","swi","div.l","udiv.l","mod.l","umod.l","brk","ldo.b","sto.b","ldo.s","sto.s"};
    string c_f2_mnem [4]  = '{"inc","dec","gsr","ssr"};
    string c_f3_mnem [10] = '{"beq","bne","blt","bgt","bltu","bgtu","bge","ble","bgeu","bleu"};

    function automatic string f_reg(input logic [3:0] r);
        if (r == 4'd0) return "fp";
        if (r == 4'd1) return "sp";
        return $sformatf("r%0d", r - 4'd2);
    endfunction

    always @(posedge clk_i) begin
        if (!rst_i && !bus.flush_i && w_in) begin
            if (w_dec.cls == c_CLS_ILL)
                $display("\tbad");
            else if (!w_op[15])
                $display("\t%s\t$%s,\t$%s", c_f1_mnem[w_op[13:8]], f_reg(w_op[7:4]), f_reg(w_op[3:0]));
            else if (!w_op[14])
                $display("\t%s\t0x%0h", c_f2_mnem[w_op[13:12]], w_dec.imm);
            else
                $display("\t%s\t0x%0h", c_f3_mnem[w_op[13:10]], w_dec.imm);
        end
    end
`endif
endmodule
`default_nettype wire

// File: tb/tb_cpu_decode_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cpu_decode_stage
//  Description : Scoreboard bench for cpu_decode_stage with directed vectors.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cpu_decode_stage;
    typedef struct {
        logic [3:0]  cls, alu, ra, rb, cond;
        logic [31:0] imm, pc;
        logic [1:0]  sz;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   exp_ill = 0;
    exp_t exp_q[$];

    cpu_decode_stage_if #(.DATA_W(32), .ADDR_W(32), .CNT_W(8)) bus ();

    cpu_decode_stage #(.DATA_W(32), .ADDR_W(32), .CNT_W(8)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the beat was accepted.
    task automatic send(input logic [15:0] op, input logic [31:0] opd, input logic [31:0] pc,
                        input logic [3:0] cls, input logic [3:0] alu, input logic [3:0] ra,
                        input logic [3:0] rb, input logic [3:0] cond, input logic [31:0] imm,
                        input logic [1:0] sz);
        exp_t e;
        int   t = 0;
        bus.valid_i = 1'b1; bus.opcode_i = op; bus.operand_i = opd; bus.pc_i = pc;
        @(negedge clk);
        while (!bus.ready_o && t < 200) begin
            tick(); @(negedge clk); t++;
        end
        if (!bus.ready_o) begin
            checks++; errors++;
            $display("FAIL accept timeout op=0x%h: ready_o 0, required 1", op);
        end else begin
            e.cls = cls; e.alu = alu; e.ra = ra; e.rb = rb; e.cond = cond;
            e.imm = imm; e.pc = pc; e.sz = sz;
            exp_q.push_back(e);
            if (cls == 4'd15 && exp_ill != 255) exp_ill++;
        end
        tick();
        bus.valid_i = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin tick(); n++; end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d beats outstanding, required 0", exp_q.size());
        end
    endtask

    // Monitor: every output transfer is compared against the oldest expectation.
    initial begin
        exp_t e;
        logic ok;
        forever begin
            @(negedge clk);
            if (!rst && bus.valid_o && bus.ready_i) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected beat: got pc=0x%h cls=%0d, required no output", bus.pc_o, bus.class_o);
                end else begin
                    e = exp_q.pop_front();
                    ok = (bus.class_o == e.cls) && (bus.alu_op_o == e.alu) && (bus.rega_o == e.ra) &&
                         (bus.regb_o == e.rb) && (bus.cond_o == e.cond) && (bus.imm_o == e.imm) &&
                         (bus.mem_size_o == e.sz) && (bus.pc_o == e.pc) &&
                         (bus.illegal_o == (e.cls == 4'd15));
                    if (!ok) begin
                        errors++;
                        $display("FAIL beat pc=0x%h: got cls=%0d alu=%0d ra=%0d rb=%0d cond=%0d imm=0x%h sz=%0d ill=%0d pc=0x%h, required cls=%0d alu=%0d ra=%0d rb=%0d cond=%0d imm=0x%h sz=%0d ill=%0d",
                                 e.pc, bus.class_o, bus.alu_op_o, bus.rega_o, bus.regb_o, bus.cond_o, bus.imm_o,
                                 bus.mem_size_o, bus.illegal_o, bus.pc_o, e.cls, e.alu, e.ra, e.rb, e.cond,
                                 e.imm, e.sz, (e.cls == 4'd15));
                    end
                end
            end
        end
    end

    initial begin
        bus.valid_i = 1'b0; bus.flush_i = 1'b0; bus.ready_i = 1'b1;
        bus.opcode_i = '0; bus.operand_i = '0; bus.pc_i = '0;
        tick(); tick();
        @(negedge clk);
        chk("reset valid_o", bus.valid_o, 0);
        chk("reset ready_o", bus.ready_o, 1);
        chk("reset ill_count_o", bus.ill_count_o, 0);
        chk("reset class_o", bus.class_o, 0);
        chk("reset imm_o", bus.imm_o, 0);
        chk("reset pc_o", bus.pc_o, 0);
        tick();
        rst = 1'b0;

        // ALU form1 and branch targets including wrap-around
        send(16'h0534, 32'hDEADBEEF, 32'h100, 4'd1, 4'd0, 4'd3, 4'd4, 4'd0, 32'hDEADBEEF, 2'd2);
        send(16'hC3FF, 32'h0, 32'h1000, 4'd5, 4'd0, 4'd0, 4'd0, 4'd0, 32'h1000, 2'd2);
        send(16'hC401, 32'h0, 32'hFFFFFFFE, 4'd5, 4'd0, 4'd0, 4'd0, 4'd1, 32'h2, 2'd2);
        // Class coverage and illegal-range boundaries
        send(16'h2f56, 32'h5, 32'h104, 4'd1, 4'd8, 4'd5, 4'd6, 4'd0, 32'h5, 2'd2);
        send(16'hA100, 32'h0, 32'h106, 4'd12, 4'd0, 4'd1, 4'd0, 4'd0, 32'h0, 2'd2);
        send(16'h3000, 32'h77, 32'h108, 4'd10, 4'd0, 4'd0, 4'd0, 4'd0, 32'h77, 2'd2);
        send(16'h3900, 32'h9, 32'h10A, 4'd4, 4'd0, 4'd0, 4'd0, 4'd0, 32'h9, 2'd1);
        send(16'h3A00, 32'h0, 32'h10C, 4'd15, 4'd0, 4'd0, 4'd0, 4'd0, 32'h0, 2'd2);
        send(16'h0F00, 32'h0, 32'h10E, 4'd15, 4'd0, 4'd0, 4'd0, 4'd0, 32'h0, 2'd2);
        send(16'h1900, 32'h0, 32'h110, 4'd7, 4'd0, 4'd0, 4'd0, 4'd0, 32'h0, 2'd2);
        send(16'h1000, 32'h0, 32'h112, 4'd15, 4'd0, 4'd0, 4'd0, 4'd0, 32'h0, 2'd2);
        send(16'h3500, 32'h0, 32'h114, 4'd11, 4'd0, 4'd0, 4'd0, 4'd0, 32'h0, 2'd2);
        send(16'h0400, 32'h0, 32'h116, 4'd8, 4'd0, 4'd0, 4'd0, 4'd0, 32'h0, 2'd2);
        drain();
        @(negedge clk);
        chk("ill_count after 3 illegal", bus.ill_count_o, 3);
        tick();

        // Backpressure: ready_o drops after two accepts, then four drain in order
        bus.ready_i = 1'b0;
        send(16'h0212, 32'h11, 32'h200, 4'd2, 4'd0, 4'd1, 4'd2, 4'd0, 32'h11, 2'd2);
        send(16'h1c34, 32'h22, 32'h202, 4'd3, 4'd0, 4'd3, 4'd4, 4'd0, 32'h22, 2'd0);
        @(negedge clk);
        chk("ready_o after 2 accepts", bus.ready_o, 0);
        chk("held pc_o under stall", bus.pc_o, 32'h200);
        tick();
        fork
            begin
                send(16'h8a05, 32'h0, 32'h204, 4'd1, 4'd0, 4'd10, 4'd0, 4'd0, 32'h5, 2'd2);
                send(16'h9307, 32'h0, 32'h206, 4'd1, 4'd1, 4'd3, 4'd0, 4'd0, 32'h7, 2'd2);
            end
            begin
                repeat (3) tick();
                bus.ready_i = 1'b1;
            end
        join
        drain();

        // Flush from TWO with a beat presented in the flush cycle
        bus.ready_i = 1'b0;
        send(16'h0212, 32'h0, 32'h300, 4'd2, 4'd0, 4'd1, 4'd2, 4'd0, 32'h0, 2'd2);
        send(16'h0212, 32'h0, 32'h302, 4'd2, 4'd0, 4'd1, 4'd2, 4'd0, 32'h0, 2'd2);
        bus.valid_i = 1'b1; bus.opcode_i = 16'h0100; bus.pc_i = 32'h304; bus.flush_i = 1'b1;
        exp_q.delete();
        tick();
        bus.valid_i = 1'b0; bus.flush_i = 1'b0;
        @(negedge clk);
        chk("flush valid_o", bus.valid_o, 0);
        chk("flush ready_o", bus.ready_o, 1);
        tick();
        bus.ready_i = 1'b1;
        repeat (5) tick();

        // Flush from ONE with an illegal beat: must not be counted
        bus.ready_i = 1'b0;
        send(16'h0534, 32'h0, 32'h400, 4'd1, 4'd0, 4'd3, 4'd4, 4'd0, 32'h0, 2'd2);
        bus.valid_i = 1'b1; bus.opcode_i = 16'h4000; bus.pc_i = 32'h402; bus.flush_i = 1'b1;
        exp_q.delete();
        tick();
        bus.valid_i = 1'b0; bus.flush_i = 1'b0;
        @(negedge clk);
        chk("flush ONE valid_o", bus.valid_o, 0);
        chk("flushed illegal not counted", bus.ill_count_o, 3);
        tick();
        bus.ready_i = 1'b1;
        repeat (3) tick();

        // Saturation of the illegal counter
        for (int i = 0; i < 300; i++)
            send(16'h4000, 32'h0, 32'h1000 + 32'(2 * i), 4'd15, 4'd0, 4'd0, 4'd0, 4'd0, 32'h0, 2'd2);
        drain();
        @(negedge clk);
        chk("ill_count saturated", bus.ill_count_o, 32'(exp_ill));
        chk("ill_count 0xFF", bus.ill_count_o, 8'hFF);
        tick();

        // Reset mid-stream clears buffer and counter
        bus.ready_i = 1'b0;
        send(16'h0534, 32'h0, 32'h500, 4'd1, 4'd0, 4'd3, 4'd4, 4'd0, 32'h0, 2'd2);
        exp_q.delete();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("mid reset valid_o", bus.valid_o, 0);
        chk("mid reset ready_o", bus.ready_o, 1);
        chk("mid reset ill_count_o", bus.ill_count_o, 0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
